// File: rtl/zbb_seq_pkg.sv
// Shared definitions for the Zbb multi-cycle sequencer.
// Holds the instruction field constants for CLZ/CTZ/CPOP/ROL/ROR, the rs2
// sub-codes that pick between the count ops, the internal op encoding,
// the FSM state encoding, and the instruction decode helper.
package zbb_seq_pkg;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_ZBB    = 7'b0110000;
    localparam logic [2:0] F3_CNT    = 3'b001;
    localparam logic [2:0] F3_ROL    = 3'b001;
    localparam logic [2:0] F3_ROR    = 3'b101;
    localparam logic [4:0] RS2_CLZ   = 5'd0;
    localparam logic [4:0] RS2_CTZ   = 5'd1;
    localparam logic [4:0] RS2_CPOP  = 5'd2;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLZ  = 3'd1,
        OP_CTZ  = 3'd2,
        OP_CPOP = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Map the raw instruction fields onto the internal op; OP_NONE for
    // everything this block does not own (including other Zbb ops).
    function automatic op_e decode_op(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [4:0] rs2);
        op_e r;
        r = OP_NONE;
        if (f7 == F7_ZBB) begin
            if (opc == OPC_OPIMM && f3 == F3_CNT) begin
                case (rs2)
                    RS2_CLZ:  r = OP_CLZ;
                    RS2_CTZ:  r = OP_CTZ;
                    RS2_CPOP: r = OP_CPOP;
                    default:  r = OP_NONE;
                endcase
            end else if (opc == OPC_OP && f3 == F3_ROL) begin
                r = OP_ROL;
            end else if (opc == OPC_OP && f3 == F3_ROR) begin
                r = OP_ROR;
            end else begin
                r = OP_NONE;
            end
        end else begin
            r = OP_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/zbb_seq_step.sv
// One iteration step of the sequencer (purely combinational).
// Ports:
//   chunk     in  BPC  operand chunk (top bits for CLZ, low bits otherwise)
//   op        in  3    internal op
//   amt       in  5    remaining rotate amount
//   cnt_inc   out 4    value to add to the running count
//   found     out 1    CLZ/CTZ: chunk holds the first set bit
//   rot_step  out 4    rotate distance for this cycle, min(amt, BPC)
module zbb_seq_step
    import zbb_seq_pkg::*;
#(
    parameter int BPC = 4
) (
    input  logic [BPC-1:0] chunk,
    input  op_e            op,
    input  logic [4:0]     amt,
    output logic [3:0]     cnt_inc,
    output logic           found,
    output logic [3:0]     rot_step
);

    logic [3:0] lz_s;
    logic [3:0] tz_s;
    logic [3:0] pop_s;

    // Leading/trailing zero and population counts of the chunk; a zero
    // chunk yields BPC for both zero counts.
    always_comb begin
        lz_s  = 4'(BPC);
        tz_s  = 4'(BPC);
        pop_s = 4'd0;
        for (int i = 0; i < BPC; i++) begin
            lz_s  = chunk[i] ? 4'(BPC - 1 - i) : lz_s;
            pop_s = pop_s + {3'd0, chunk[i]};
        end
        for (int i = BPC - 1; i >= 0; i--) begin
            tz_s = chunk[i] ? 4'(i) : tz_s;
        end
    end

    // Select the step outputs for the active op.
    always_comb begin
        cnt_inc  = 4'd0;
        found    = 1'b0;
        rot_step = 4'd0;
        case (op)
            OP_CLZ: begin
                cnt_inc = lz_s;
                found   = |chunk;
            end
            OP_CTZ: begin
                cnt_inc = tz_s;
                found   = |chunk;
            end
            OP_CPOP: begin
                cnt_inc = pop_s;
            end
            OP_ROL, OP_ROR: begin
                rot_step = (amt < 5'(BPC)) ? amt[3:0] : 4'(BPC);
            end
            default: begin
                cnt_inc = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/zbb_seq.sv
// Multi-cycle sequencer for Zbb CLZ, CTZ, CPOP, ROL and ROR.
// Decodes its own instructions, stalls the core while it walks the operand
// BITS_PER_CYCLE bits per cycle, then presents the result for one cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               instruction in execute is valid
//   flush               abandon an op that is in RUN
//   cmdOp/F3/F7/Rs2     instruction fields
//   din_rs1, din_rs2    operands (rotate amount is din_rs2[4:0])
//   isSeqInstr          fields decode to one of the five ops
//   stall               hold the pipeline this cycle
//   done                one-cycle result valid pulse
//   dout_rd             result, zero whenever done is low
module zbb_seq
    import zbb_seq_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [6:0]  cmdOp,
    input  logic [2:0]  cmdF3,
    input  logic [6:0]  cmdF7,
    input  logic [4:0]  cmdRs2,
    input  logic [31:0] din_rs1,
    input  logic [31:0] din_rs2,
    output logic        isSeqInstr,
    output logic        stall,
    output logic        done,
    output logic [31:0] dout_rd
);

    localparam logic [5:0] LAST_IDX = 6'(32 / BITS_PER_CYCLE - 1);

    state_e      state_r, state_next_s;
    op_e         op_r, op_next_s, dec_op_s;
    logic [31:0] shreg_r, shreg_next_s;
    logic [5:0]  cnt_r, cnt_next_s;
    logic [4:0]  amt_r, amt_next_s;
    logic [5:0]  idx_r, idx_next_s;

    logic [BITS_PER_CYCLE-1:0] chunk_s;
    logic [3:0]  cnt_inc_s;
    logic        found_s;
    logic [3:0]  rot_step_s;
    logic [63:0] rol_wide_s;
    logic [63:0] ror_wide_s;
    logic        unused_rs2_s;

    assign dec_op_s     = decode_op(cmdOp, cmdF3, cmdF7, cmdRs2);
    assign isSeqInstr   = (dec_op_s != OP_NONE);
    assign unused_rs2_s = ^din_rs2[31:5];

    // CLZ scans from the MSB end; every other op consumes the low bits.
    assign chunk_s = (op_r == OP_CLZ) ? shreg_r[31 -: BITS_PER_CYCLE]
                                      : shreg_r[BITS_PER_CYCLE-1:0];

    // Doubling the word turns a rotate into a plain shift of a window.
    assign rol_wide_s = {shreg_r, shreg_r} << rot_step_s;
    assign ror_wide_s = {shreg_r, shreg_r} >> rot_step_s;

    zbb_seq_step #(
        .BPC (BITS_PER_CYCLE)
    ) u_step (
        .chunk    (chunk_s),
        .op       (op_r),
        .amt      (amt_r),
        .cnt_inc  (cnt_inc_s),
        .found    (found_s),
        .rot_step (rot_step_s)
    );

    // Next-state, datapath updates and outputs.
    always_comb begin
        state_next_s = state_r;
        op_next_s    = op_r;
        shreg_next_s = shreg_r;
        cnt_next_s   = cnt_r;
        amt_next_s   = amt_r;
        idx_next_s   = idx_r;
        stall        = 1'b0;
        done         = 1'b0;
        dout_rd      = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (start && isSeqInstr) begin
                    stall        = 1'b1;
                    op_next_s    = dec_op_s;
                    shreg_next_s = din_rs1;
                    amt_next_s   = din_rs2[4:0];
                    cnt_next_s   = 6'd0;
                    idx_next_s   = 6'd0;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                stall = 1'b1;
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    idx_next_s = idx_r + 6'd1;
                    case (op_r)
                        OP_CLZ, OP_CTZ: begin
                            cnt_next_s   = cnt_r + 6'(cnt_inc_s);
                            shreg_next_s = (op_r == OP_CLZ) ? (shreg_r << BITS_PER_CYCLE)
                                                            : (shreg_r >> BITS_PER_CYCLE);
                            if (found_s || idx_r == LAST_IDX) begin
                                state_next_s = ST_DONE;
                            end else begin
                                state_next_s = ST_RUN;
                            end
                        end
                        OP_CPOP: begin
                            cnt_next_s   = cnt_r + 6'(cnt_inc_s);
                            shreg_next_s = shreg_r >> BITS_PER_CYCLE;
                            if (idx_r == LAST_IDX) begin
                                state_next_s = ST_DONE;
                            end else begin
                                state_next_s = ST_RUN;
                            end
                        end
                        OP_ROL, OP_ROR: begin
                            shreg_next_s = (op_r == OP_ROL) ? rol_wide_s[63:32] : ror_wide_s[31:0];
                            amt_next_s   = amt_r - 5'(rot_step_s);
                            // amt==0 also lands here: one cycle, rotate by zero.
                            if (amt_r == 5'(rot_step_s)) begin
                                state_next_s = ST_DONE;
                            end else begin
                                state_next_s = ST_RUN;
                            end
                        end
                        default: begin
                            state_next_s = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                dout_rd      = (op_r == OP_ROL || op_r == OP_ROR) ? shreg_r : {26'd0, cnt_r};
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= OP_NONE;
            shreg_r <= 32'd0;
            cnt_r   <= 6'd0;
            amt_r   <= 5'd0;
            idx_r   <= 6'd0;
        end else begin
            state_r <= state_next_s;
            op_r    <= op_next_s;
            shreg_r <= shreg_next_s;
            cnt_r   <= cnt_next_s;
            amt_r   <= amt_next_s;
            idx_r   <= idx_next_s;
        end
    end

endmodule

// File: tb/tb_zbb_seq.sv
// Self-checking bench for zbb_seq. Two instances (4 and 1 bits per cycle)
// share instruction fields and operands but have separate start lines.
// Expected results and latencies come from a behavioural model built on
// the instruction definitions (bit scans, $countones, bitwise rotation).
module tb_zbb_seq;

    localparam int K_CLZ = 0, K_CTZ = 1, K_CPOP = 2, K_ROL = 3, K_ROR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        flush = 1'b0;
    logic [6:0]  opc = 7'd0, f7 = 7'd0;
    logic [2:0]  f3 = 3'd0;
    logic [4:0]  rs2f = 5'd0;
    logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
    logic        is_seq_a, stall_a, done_a, is_seq_b, stall_b, done_b;
    logic [31:0] dout_a, dout_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    zbb_seq #(.BITS_PER_CYCLE(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .flush(flush),
        .cmdOp(opc), .cmdF3(f3), .cmdF7(f7), .cmdRs2(rs2f),
        .din_rs1(rs1), .din_rs2(rs2),
        .isSeqInstr(is_seq_a), .stall(stall_a), .done(done_a), .dout_rd(dout_a)
    );

    zbb_seq #(.BITS_PER_CYCLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .flush(flush),
        .cmdOp(opc), .cmdF3(f3), .cmdF7(f7), .cmdRs2(rs2f),
        .din_rs1(rs1), .din_rs2(rs2),
        .isSeqInstr(is_seq_b), .stall(stall_b), .done(done_b), .dout_rd(dout_b)
    );

    // ---------------- reference model ----------------
    function automatic int ref_clz(input logic [31:0] a);
        int n = 0;
        while (n < 32 && !a[31 - n]) n++;
        return n;
    endfunction

    function automatic int ref_ctz(input logic [31:0] a);
        int n = 0;
        while (n < 32 && !a[n]) n++;
        return n;
    endfunction

    function automatic logic [31:0] ref_res(input int kind, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = a;
        case (kind)
            K_CLZ:  r = 32'(ref_clz(a));
            K_CTZ:  r = 32'(ref_ctz(a));
            K_CPOP: r = 32'($countones(a));
            K_ROL:  repeat (int'(b[4:0])) r = {r[30:0], r[31]};
            K_ROR:  repeat (int'(b[4:0])) r = {r[0], r[31:1]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_run(input int kind, input logic [31:0] a, input logic [31:0] b, input int bpc);
        int amt;
        amt = int'(b[4:0]);
        case (kind)
            K_CLZ:   return (a == 32'd0) ? 32 / bpc : ref_clz(a) / bpc + 1;
            K_CTZ:   return (a == 32'd0) ? 32 / bpc : ref_ctz(a) / bpc + 1;
            K_CPOP:  return 32 / bpc;
            default: return (amt == 0) ? 1 : (amt + bpc - 1) / bpc;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic set_fields(input int kind);
        f7 = 7'b0110000;
        case (kind)
            K_CLZ:  begin opc = 7'b0010011; f3 = 3'b001; rs2f = 5'd0; end
            K_CTZ:  begin opc = 7'b0010011; f3 = 3'b001; rs2f = 5'd1; end
            K_CPOP: begin opc = 7'b0010011; f3 = 3'b001; rs2f = 5'd2; end
            K_ROL:  begin opc = 7'b0110011; f3 = 3'b001; rs2f = 5'd7; end
            default: begin opc = 7'b0110011; f3 = 3'b101; rs2f = 5'd9; end
        endcase
    endtask

    // Issue one instruction on the chosen instance and hold it until done
    // (bounded). Reports stall cycles before done, the result, whether done
    // came, and whether dout_rd was nonzero without done or stall was high
    // during done.
    task automatic exec(input int sel, input int kind, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output logic [31:0] res, output bit got, output bit odd);
        set_fields(kind);
        rs1 = a;
        rs2 = b;
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        stalls = 0; got = 1'b0; odd = 1'b0; res = 32'd0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (((sel == 0) ? done_a : done_b) === 1'b1) begin
                got = 1'b1;
                res = (sel == 0) ? dout_a : dout_b;
                if (((sel == 0) ? stall_a : stall_b) !== 1'b0) odd = 1'b1;
            end else begin
                if (((sel == 0) ? stall_a : stall_b) === 1'b1) stalls++;
                if (((sel == 0) ? dout_a : dout_b) !== 32'd0) odd = 1'b1;
            end
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Run one op and compare result, latency and output hygiene.
    task automatic check_op(input string name, input int sel, input int kind,
                            input logic [31:0] a, input logic [31:0] b);
        int stalls, bpc, exp_stalls;
        logic [31:0] res, exp_res;
        bit got, odd;
        bpc = (sel == 0) ? 4 : 1;
        exp_res = ref_res(kind, a, b);
        exp_stalls = 1 + ref_run(kind, a, b, bpc);
        exec(sel, kind, a, b, stalls, res, got, odd);
        total++;
        if (got !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: no done (a=%h b=%h)", name, a, b);
        end else begin
            total++;
            if (res !== exp_res) begin
                bad++;
                $display("FAIL %s result: got %h want %h (a=%h b=%h)", name, res, exp_res, a, b);
            end
            total++;
            if (stalls !== exp_stalls) begin
                bad++;
                $display("FAIL %s stall cycles: got %0d want %0d (a=%h b=%h)", name, stalls, exp_stalls, a, b);
            end
            total++;
            if (odd !== 1'b0) begin
                bad++;
                $display("FAIL %s output hygiene: got %0d want 0", name, odd);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({stall_a, done_a, stall_b, done_b} !== 4'b0000) begin
            bad++;
            $display("FAIL reset stall/done: got %b want 0000", {stall_a, done_a, stall_b, done_b});
        end
        total++;
        if (dout_a !== 32'd0 || dout_b !== 32'd0) begin
            bad++;
            $display("FAIL reset dout: got %h/%h want 0", dout_a, dout_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_op("clz_15", 0, K_CLZ, 32'h0001_0000, 32'd0);
        check_op("ctz_zero", 0, K_CTZ, 32'd0, 32'd0);
        check_op("cpop_ones", 0, K_CPOP, 32'hFFFF_FFFF, 32'd0);
        check_op("rol_8", 0, K_ROL, 32'h1234_5678, 32'd8);
        check_op("ror_1", 0, K_ROR, 32'h8000_0001, 32'd1);
        check_op("ror_32", 0, K_ROR, 32'hDEAD_BEEF, 32'd32);
        check_op("clz_msb", 0, K_CLZ, 32'h8000_0000, 32'd0);
        check_op("ctz_16", 0, K_CTZ, 32'h0001_0000, 32'd0);
        check_op("rol_31", 0, K_ROL, 32'h0000_0003, 32'd31);
        // done must be a single-cycle pulse
        @(negedge clk);
        total++;
        if (done_a !== 1'b0 || dout_a !== 32'd0) begin
            bad++;
            $display("FAIL done_pulse: got done=%b dout=%h want 0/0", done_a, dout_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bpc1();
        check_op("b1_clz_msb", 1, K_CLZ, 32'h8000_0000, 32'd0);
        check_op("b1_cpop", 1, K_CPOP, 32'h0F0F_0F0F, 32'd0);
        check_op("b1_ror_5", 1, K_ROR, 32'h0000_00F1, 32'd5);
    endtask

    task automatic test_non_seq();
        // ADD, ANDN, SEXT.B: none belong to this block
        logic [16:0] enc [3];
        enc[0] = {7'b0110011, 3'b000, 7'b0000000};
        enc[1] = {7'b0110011, 3'b111, 7'b0100000};
        enc[2] = {7'b0010011, 3'b001, 7'b0110000};
        for (int i = 0; i < 3; i++) begin
            {opc, f3, f7} = enc[i];
            rs2f = 5'd4;
            rs1 = $urandom;
            start_a = 1'b1;
            start_b = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                total++;
                if ({is_seq_a, stall_a, done_a, stall_b, done_b} !== 5'b00000) begin
                    bad++;
                    $display("FAIL non_seq %0d: got %b want 00000", i, {is_seq_a, stall_a, done_a, stall_b, done_b});
                end
                @(posedge clk); #1;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        set_fields(K_ROR);
        #1;
        total++;
        if (is_seq_a !== 1'b1) begin
            bad++;
            $display("FAIL decode_ror: got %b want 1", is_seq_a);
        end
    endtask

    task automatic test_flush();
        bit seen_done;
        set_fields(K_CPOP);
        rs1 = 32'h1234_5678;
        start_a = 1'b1;
        @(posedge clk); #1;            // RUN 1
        start_a = 1'b0;
        @(posedge clk); #1;            // RUN 2
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (stall_a !== 1'b1) begin
            bad++;
            $display("FAIL flush_run_stall: got %b want 1", stall_a);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (stall_a !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall_drop: got %b want 0", stall_a);
        end
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done_a === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_done: got %b want 0", seen_done);
        end
        @(posedge clk); #1;
        check_op("after_flush", 0, K_CPOP, 32'h0000_00FF, 32'd0);
    endtask

    task automatic test_rst_mid_run();
        set_fields(K_CPOP);
        rs1 = 32'hFFFF_FFFF;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({stall_a, done_a} !== 2'b00 || dout_a !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_run: got stall=%b done=%b dout=%h want 0", stall_a, done_a, dout_a);
        end
        @(posedge clk); #1;
        check_op("after_rst", 0, K_CLZ, 32'h0000_0100, 32'd0);
    endtask

    task automatic test_back_to_back();
        // second exec starts in the cycle right after DONE; its stall count
        // only matches if it is accepted immediately
        check_op("b2b_first", 0, K_CLZ, 32'h0000_F000, 32'd0);
        check_op("b2b_second", 0, K_CLZ, 32'h0400_0000, 32'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [31:0] a, b;
            kind = int'($urandom_range(0, 4));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: a = a >> $urandom_range(0, 31);
                1: a = a << $urandom_range(0, 31);
                2: b = b & 32'h0000_0007;
                default: a = a;
            endcase
            check_op("random", i % 2, kind, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bpc1();
        test_non_seq();
        test_flush();
        test_rst_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
